control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired, state-per-step control unit for the single-bus CPU datapath. Each clock it reads the instruction register and the CON flip-flop and emits the control word (bus-source, register-load, select-and-encode, memory and ALU strobes) for the current T-step. It sequences fetch, decode and execute for every instruction class, then loops back to fetch. It also handles halt and stop requests.

## Interface
- No parameters; opcode encodings are fixed (see Operation).
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  reset, synchronous, active-high
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON  in  1  branch flag from the CON flip-flop
- stop  in  1  level; halt after the current instruction retires
- PCout, MDRout, RZoutLo, RZoutHi, HIout, LOout, RCout  out  1 each  bus-source selects; at most one high per cycle
- PCin, IRin, MARin, MDRin, RYin, RZinLo, RZinHi, HIin, LOin, CONin  out  1 each  register load enables
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls
- IncPC, MDRread, RAMwrite  out  1 each  PC increment, memory read into MDR, memory write
- run  out  1  high while executing; low in RESET and HALT
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Outputs are Moore: a pure decode of the state register, with no combinational path from IR or CON to the outputs. The only exception is PCin in BR_T6, which is gated by CON.
- Every strobe not listed for a state is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, RZinLo
  - T1: RZoutLo, PCin, MDRread, MDRin
  - T2: MDRout, IRin
  - T3: decode IR[31:27] into the first execute state
- Opcodes and execute steps (T3 onward):
  - 00011–01011, ALU reg-reg: Grb Rout RYin; Grc Rout RZinLo; RZoutLo Gra Rin
  - 01100–01110, ALU immediate: Grb Rout RYin; RCout RZinLo; RZoutLo Gra Rin
  - 00000 ld: Grb BAout RYin; RCout RZinLo; RZoutLo MARin; MDRread MDRin; MDRout Gra Rin
  - 00001 ldi: Grb BAout RYin; RCout RZinLo; RZoutLo Gra Rin
  - 00010 st: same three address steps as ld; then Gra Rout MDRin (MDRread=0); then RAMwrite
  - 01111 mul, 10000 div: Gra Rout RYin; Grb Rout RZinLo RZinHi; RZoutLo LOin; RZoutHi HIin
  - 10010 br: Gra Rout CONin; PCout RYin; RCout RZinLo; RZoutLo PCin only if CON=1, otherwise no load
  - 10011 jr: Gra Rout PCin
  - 10100 jal: PCout Grb Rin; Gra Rout PCin
  - 10111 mfhi: HIout Gra Rin
  - 11000 mflo: LOout Gra Rin
  - 11001 nop: one idle step
  - 11010 halt: go to HALT
  - Any other opcode: one step with illegal=1, then fetch T0
- After the last execute step:
  - If stop=1 sampled that cycle, go to HALT.
  - Otherwise go to fetch T0.
- HALT: all strobes 0, run=0. Leave only via clear.
- RESET state: entered on clear. All outputs 0. Next cycle goes to fetch T0 with run=1.

## Timing
- One state per cycle; no wait states.
- Instruction length in cycles (fetch included):
  - reg-reg, immediate, ldi: 6
  - ld, st: 8
  - mul, div, br: 7
  - jr, mfhi, mflo, nop, illegal: 4
  - jal: 5
- The CON value used in BR_T6 is the value present in BR_T6. The flip-flop was loaded at the edge ending BR_T3.
- stop is sampled only in an instruction's final cycle; mid-instruction assertion is ignored until then.
- clear has priority over every transition, including mid-instruction. Next state is RESET and all outputs are 0 in the cycle after the clear edge; no partial write completes.
- Simultaneous halt opcode and stop: result is HALT.

## Test plan
- clear held 2 cycles, then released with IR=0x1A1A0000 (add R4,R3,R4) → sequence T0..T5 matches the reg-reg list; Gra Rin high in cycle 6; back at T0 in cycle 7.
- ld (opcode 00000) → MARin in T5, MDRread+MDRin in T6, MDRout+Gra+Rin in T7; RAMwrite never asserted.
- st → RAMwrite high exactly one cycle (T7) and MDRread=0 throughout execute.
- br twice, with CON=0 and then CON=1 → PCin in BR_T6 absent then present; both instructions take 7 cycles.
- Opcode 11111 → illegal pulses once in T3, fetch restarts at cycle 4; then halt opcode → run=0 held for 20 cycles until clear.
- stop raised in T4 of mul → instruction finishes (HIin in T6), then HALT; clear asserted in ld T5 → all outputs 0 next cycle, then RESET → T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired one-state-per-T-step control unit for the single-bus CPU datapath.
// Control outputs decode only the state register. The one exception is PCin in BR_T6, which is gated by CON.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        PCout, MDRout, RZoutLo, RZoutHi, HIout, LOout, RCout,
  output logic        PCin, IRin, MARin, MDRin, RYin, RZinLo, RZinHi, HIin, LOin, CONin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        IncPC, MDRread, RAMwrite,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [5:0] {
    S_RESET, S_HALT, S_F0, S_F1, S_F2,
    S_RR3, S_RR4, S_RR5, S_IM3, S_IM4, S_IM5,
    S_LD3, S_LD4, S_LD5, S_LD6, S_LD7, S_LDI3, S_LDI4, S_LDI5,
    S_ST3, S_ST4, S_ST5, S_ST6, S_ST7, S_MD3, S_MD4, S_MD5, S_MD6,
    S_BR3, S_BR4, S_BR5, S_BR6, S_JR3, S_JAL3, S_JAL4,
    S_MFHI3, S_MFLO3, S_NOP3, S_HLT3, S_ILL3
  } state_t;

  state_t      state, nextState;
  logic [4:0]  opcode;
  logic        unusedIrBits;

  assign opcode       = IR[31:27];
  assign unusedIrBits = ^IR[26:0];

  always_ff @(posedge clock) begin
    if (clear) state <= S_RESET;
    else       state <= nextState;
  end

  // IR is decoded on the edge that leaves T2, so T3 already drives the first execute step
  always_comb begin
    nextState = S_RESET;
    case (state)
      S_RESET: nextState = S_F0;
      S_HALT:  nextState = S_HALT;
      S_F0:    nextState = S_F1;
      S_F1:    nextState = S_F2;
      S_F2: begin
        if (opcode >= 5'd3 && opcode <= 5'd11)       nextState = S_RR3;
        else if (opcode >= 5'd12 && opcode <= 5'd14) nextState = S_IM3;
        else begin
          case (opcode)
            5'd0:    nextState = S_LD3;
            5'd1:    nextState = S_LDI3;
            5'd2:    nextState = S_ST3;
            5'd15,
            5'd16:   nextState = S_MD3;
            5'd18:   nextState = S_BR3;
            5'd19:   nextState = S_JR3;
            5'd20:   nextState = S_JAL3;
            5'd23:   nextState = S_MFHI3;
            5'd24:   nextState = S_MFLO3;
            5'd25:   nextState = S_NOP3;
            5'd26:   nextState = S_HLT3;
            default: nextState = S_ILL3;
          endcase
        end
      end
      S_RR3:  nextState = S_RR4;
      S_RR4:  nextState = S_RR5;
      S_IM3:  nextState = S_IM4;
      S_IM4:  nextState = S_IM5;
      S_LD3:  nextState = S_LD4;
      S_LD4:  nextState = S_LD5;
      S_LD5:  nextState = S_LD6;
      S_LD6:  nextState = S_LD7;
      S_LDI3: nextState = S_LDI4;
      S_LDI4: nextState = S_LDI5;
      S_ST3:  nextState = S_ST4;
      S_ST4:  nextState = S_ST5;
      S_ST5:  nextState = S_ST6;
      S_ST6:  nextState = S_ST7;
      S_MD3:  nextState = S_MD4;
      S_MD4:  nextState = S_MD5;
      S_MD5:  nextState = S_MD6;
      S_BR3:  nextState = S_BR4;
      S_BR4:  nextState = S_BR5;
      S_BR5:  nextState = S_BR6;
      S_JAL3: nextState = S_JAL4;
      S_HLT3: nextState = S_HALT;
      S_RR5, S_IM5, S_LD7, S_LDI5, S_ST7, S_MD6, S_BR6, S_JR3, S_JAL4,
      S_MFHI3, S_MFLO3, S_NOP3, S_ILL3:
        nextState = stop ? S_HALT : S_F0;
      default: nextState = S_RESET;
    endcase
  end

  always_comb begin
    {PCout, MDRout, RZoutLo, RZoutHi, HIout, LOout, RCout} = '0;
    {PCin, IRin, MARin, MDRin, RYin, RZinLo, RZinHi, HIin, LOin, CONin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {IncPC, MDRread, RAMwrite, illegal} = '0;
    run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_F0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZinLo = 1'b1; end
      S_F1:   begin RZoutLo = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
      S_F2:   begin MDRout = 1'b1; IRin = 1'b1; end
      S_RR3, S_IM3: begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
      S_RR4:  begin Grc = 1'b1; Rout = 1'b1; RZinLo = 1'b1; end
      S_IM4, S_LD4, S_LDI4, S_ST4, S_BR5: begin RCout = 1'b1; RZinLo = 1'b1; end
      S_RR5, S_IM5, S_LDI5: begin RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_LD3, S_LDI3, S_ST3: begin Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
      S_LD5, S_ST5: begin RZoutLo = 1'b1; MARin = 1'b1; end
      S_LD6:  begin MDRread = 1'b1; MDRin = 1'b1; end
      S_LD7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_ST6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      S_ST7:  RAMwrite = 1'b1;
      S_MD3:  begin Gra = 1'b1; Rout = 1'b1; RYin = 1'b1; end
      S_MD4:  begin Grb = 1'b1; Rout = 1'b1; RZinLo = 1'b1; RZinHi = 1'b1; end
      S_MD5:  begin RZoutLo = 1'b1; LOin = 1'b1; end
      S_MD6:  begin RZoutHi = 1'b1; HIin = 1'b1; end
      S_BR3:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
      S_BR4:  begin PCout = 1'b1; RYin = 1'b1; end
      S_BR6:  begin RZoutLo = 1'b1; PCin = CON; end
      S_JR3, S_JAL4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      S_JAL3: begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
      S_MFHI3: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_MFLO3: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_ILL3: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: randomized instruction stream compared step by step
// against a table-driven model of each instruction class's control words.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, CON, stop;
  logic [31:0] IR;
  logic PCout, MDRout, RZoutLo, RZoutHi, HIout, LOout, RCout;
  logic PCin, IRin, MARin, MDRin, RYin, RZinLo, RZinHi, HIin, LOin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, MDRread, RAMwrite, run, illegal;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .RZoutLo(RZoutLo), .RZoutHi(RZoutHi),
    .HIout(HIout), .LOout(LOout), .RCout(RCout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .RYin(RYin),
    .RZinLo(RZinLo), .RZinHi(RZinHi), .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .MDRread(MDRread), .RAMwrite(RAMwrite),
    .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  localparam logic [27:0] PCO  = 28'd1 << 27, MDRO = 28'd1 << 26, ZLO  = 28'd1 << 25;
  localparam logic [27:0] ZHO  = 28'd1 << 24, HIO  = 28'd1 << 23, LOO  = 28'd1 << 22;
  localparam logic [27:0] RCO  = 28'd1 << 21, PCI  = 28'd1 << 20, IRI  = 28'd1 << 19;
  localparam logic [27:0] MARI = 28'd1 << 18, MDRI = 28'd1 << 17, RYI  = 28'd1 << 16;
  localparam logic [27:0] ZLI  = 28'd1 << 15, ZHI  = 28'd1 << 14, HII  = 28'd1 << 13;
  localparam logic [27:0] LOI  = 28'd1 << 12, CONI = 28'd1 << 11, GRA  = 28'd1 << 10;
  localparam logic [27:0] GRB  = 28'd1 << 9,  GRC  = 28'd1 << 8,  RIN  = 28'd1 << 7;
  localparam logic [27:0] ROUT = 28'd1 << 6,  BAO  = 28'd1 << 5,  INC  = 28'd1 << 4;
  localparam logic [27:0] MRD  = 28'd1 << 3,  MWR  = 28'd1 << 2,  RUN  = 28'd1 << 1;
  localparam logic [27:0] ILL  = 28'd1;
  localparam logic [27:0] Z    = 28'd0;

  localparam int C_RR = 0, C_IM = 1, C_LD = 2, C_LDI = 3, C_ST = 4, C_MD = 5, C_BR = 6;
  localparam int C_JR = 7, C_JAL = 8, C_MFHI = 9, C_MFLO = 10, C_NOP = 11, C_HALT = 12, C_ILL = 13;

  function automatic int opClass(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return C_RR;
    if (op >= 5'd12 && op <= 5'd14) return C_IM;
    case (op)
      5'd0:         return C_LD;
      5'd1:         return C_LDI;
      5'd2:         return C_ST;
      5'd15, 5'd16: return C_MD;
      5'd18:        return C_BR;
      5'd19:        return C_JR;
      5'd20:        return C_JAL;
      5'd23:        return C_MFHI;
      5'd24:        return C_MFLO;
      5'd25:        return C_NOP;
      5'd26:        return C_HALT;
      default:      return C_ILL;
    endcase
  endfunction

  function automatic int instrLen(input int c);
    case (c)
      C_RR, C_IM, C_LDI: return 6;
      C_LD, C_ST:        return 8;
      C_MD, C_BR:        return 7;
      C_JAL:             return 5;
      default:           return 4;
    endcase
  endfunction

  // Control word expected in step k (0-based from fetch T0) of an instruction
  function automatic logic [27:0] expWord(input logic [4:0] op, input int k, input logic con);
    logic [27:0] s [5];
    case (opClass(op))
      C_RR:   s = '{GRB|ROUT|RYI, GRC|ROUT|ZLI, ZLO|GRA|RIN, Z, Z};
      C_IM:   s = '{GRB|ROUT|RYI, RCO|ZLI, ZLO|GRA|RIN, Z, Z};
      C_LD:   s = '{GRB|BAO|RYI, RCO|ZLI, ZLO|MARI, MRD|MDRI, MDRO|GRA|RIN};
      C_LDI:  s = '{GRB|BAO|RYI, RCO|ZLI, ZLO|GRA|RIN, Z, Z};
      C_ST:   s = '{GRB|BAO|RYI, RCO|ZLI, ZLO|MARI, GRA|ROUT|MDRI, MWR};
      C_MD:   s = '{GRA|ROUT|RYI, GRB|ROUT|ZLI|ZHI, ZLO|LOI, ZHO|HII, Z};
      C_BR:   s = '{GRA|ROUT|CONI, PCO|RYI, RCO|ZLI, ZLO|(con ? PCI : Z), Z};
      C_JR:   s = '{GRA|ROUT|PCI, Z, Z, Z, Z};
      C_JAL:  s = '{PCO|GRB|RIN, GRA|ROUT|PCI, Z, Z, Z};
      C_MFHI: s = '{HIO|GRA|RIN, Z, Z, Z, Z};
      C_MFLO: s = '{LOO|GRA|RIN, Z, Z, Z, Z};
      C_ILL:  s = '{ILL, Z, Z, Z, Z};
      default: s = '{Z, Z, Z, Z, Z};
    endcase
    if (k == 0) return RUN|PCO|MARI|INC|ZLI;
    if (k == 1) return RUN|ZLO|PCI|MRD|MDRI;
    if (k == 2) return RUN|MDRO|IRI;
    return RUN | s[k-3];
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [27:0] exp);
    logic [27:0] obs;
    obs = {PCout, MDRout, RZoutLo, RZoutHi, HIout, LOout, RCout,
           PCin, IRin, MARin, MDRin, RYin, RZinLo, RZinHi, HIin, LOin, CONin,
           Gra, Grb, Grc, Rin, Rout, BAout, IncPC, MDRread, RAMwrite, run, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %07h expected %07h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from fetch T0; halted reports whether HALT must follow
  task automatic runInstr(input logic [4:0] op, input logic con, input int stopStep,
                          input bit stopHold, input int clearStep, output bit halted);
    int n;
    logic [31:0] r;
    n = instrLen(opClass(op));
    halted = 1'b0;
    IR = $urandom;
    CON = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      check($sformatf("op%02h_t%0d", op, k), expWord(op, k, con));
      if (k == clearStep) begin
        clear = 1'b1;
        tick();
        check("clear_mid_instr", Z);
        clear = 1'b0;
        stop = 1'b0;
        tick();
        return;
      end
      if (k == stopStep) stop = 1'b1;
      else if (k > stopStep && !stopHold) stop = 1'b0;
      r = $urandom;
      if (k == 1) IR = {op, r[26:0]};
      else if (k >= 3) IR = r;
      CON = (opClass(op) == C_BR && k + 1 == 6) ? con : 1'($urandom);
      tick();
    end
    halted = (stop === 1'b1) || (opClass(op) == C_HALT);
    stop = 1'b0;
  endtask

  task automatic checkIdle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, Z);
      IR = $urandom;
      CON = 1'($urandom);
      stop = 1'($urandom);
      tick();
    end
    stop = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    check("reset_state", Z);
    clear = 1'b0;
    tick();
  endtask

  initial begin
    bit h;
    logic [4:0] op;
    clear = 1'b1; stop = 1'b0; CON = 1'b0; IR = 32'h1A1A0000;
    tick();
    check("reset_c0", Z);
    tick();
    check("reset_c1", Z);
    clear = 1'b0;
    tick();

    runInstr(5'd3, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd0, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd2, 1'b1, -1, 1'b0, -1, h);
    runInstr(5'd18, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd18, 1'b1, -1, 1'b0, -1, h);
    runInstr(5'd20, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd19, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd23, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd24, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd1, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd12, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd16, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd25, 1'b0, -1, 1'b0, -1, h);

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd25;
      runInstr(op, 1'($urandom), -1, 1'b0, -1, h);
    end

    runInstr(5'd31, 1'b0, -1, 1'b0, -1, h);
    runInstr(5'd17, 1'b0, -1, 1'b0, -1, h);

    // mid-instruction stop pulse is ignored; held stop halts after retirement
    runInstr(5'd15, 1'b0, 3, 1'b0, -1, h);
    runInstr(5'd15, 1'b0, 4, 1'b1, -1, h);
    if (h) checkIdle("halt_after_mul", 3);
    else checkIdle("halt_expected_mul", 0);
    doClear();

    runInstr(5'd0, 1'b0, -1, 1'b0, 5, h);
    runInstr(5'd3, 1'b0, -1, 1'b0, -1, h);

    runInstr(5'd25, 1'b0, 3, 1'b0, -1, h);
    if (h) checkIdle("halt_after_nop", 2);
    doClear();

    runInstr(5'd26, 1'b0, -1, 1'b0, -1, h);
    if (h) checkIdle("halt_opcode", 20);
    doClear();

    runInstr(5'd26, 1'b0, 3, 1'b1, -1, h);
    if (h) checkIdle("halt_with_stop", 2);
    doClear();

    runInstr(5'd3, 1'b0, -1, 1'b0, -1, h);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
